// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - state encoding and word/byte sizing helpers for the log reader
package log_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_FULL = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_FETCH     = 3'd4;
  localparam logic [2:0] ST_LATCH     = 3'd5;
  localparam logic [2:0] ST_SEND      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  function automatic int bytes_per_word(input int data_w);
    return 2 * data_w / 8;
  endfunction

  function automatic int byte_idx_width(input int data_w);
    return (bytes_per_word(data_w) > 1) ? $clog2(bytes_per_word(data_w)) : 1;
  endfunction

endpackage

// File: rtl/log_word_serializer.sv
// rtl/log_word_serializer.sv - shifts one two-lane logger word out as bytes, LSB first
module log_word_serializer
  import log_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic [2*DATA_W-1:0] i_word,
  input  logic                i_active,
  output logic [7:0]          o_tdata,
  output logic                o_tvalid,
  input  logic                i_tready,
  output logic                o_word_done
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = byte_idx_width(DATA_W);

  logic [2*DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic                w_fire;
  logic                w_last;

  assign w_fire      = i_active & i_tready;
  assign w_last      = (r_idx == IDX_W'(BPW - 1));
  assign o_tvalid    = i_active;
  assign o_tdata     = r_shift[7:0];
  assign o_word_done = w_fire & w_last;

  // Lane A sits in the low half, so shifting right sends lane A bytes first.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= '0;
    end else if (w_fire) begin
      r_shift <= r_shift >> 8;
      r_idx   <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/log_mem_reader.sv
// rtl/log_mem_reader.sv - dumps the full I/Q logger buffer as a byte stream
// Optional macro LOG_READER_AUTORUN_EN: pulse o_run_log with o_done to re-arm the logger.
module log_mem_reader
  import log_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem,
  output logic                         o_run_log,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  logic [2:0]                 r_state;
  logic [2:0]                 w_next;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic                       r_err;
  logic                       w_in_dump;
  logic                       w_abort;
  logic                       w_addr_last;
  logic                       w_word_done;
  logic                       w_send;
  logic                       w_load;

  assign w_in_dump = (r_state == ST_REQ) || (r_state == ST_SETTLE) || (r_state == ST_FETCH) ||
                     (r_state == ST_LATCH) || (r_state == ST_SEND);
  assign w_abort     = w_in_dump & ~i_mem_full;
  assign w_addr_last = &r_addr;

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (i_start) w_next = ST_WAIT_FULL;
      ST_WAIT_FULL: if (i_mem_full) w_next = ST_REQ;
      ST_REQ:       w_next = ST_SETTLE;
      ST_SETTLE:    w_next = ST_FETCH;
      ST_FETCH:     w_next = ST_LATCH;
      ST_LATCH:     w_next = ST_SEND;
      ST_SEND:      if (w_word_done) w_next = w_addr_last ? ST_DONE : ST_FETCH;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    // Losing the full flag means the logger left read mode; the buffer is no longer trustworthy.
    if (w_abort) w_next = ST_IDLE;
  end

  always_comb begin
    o_busy     = (r_state != ST_IDLE);
    o_read_log = w_in_dump;
    o_done     = (r_state == ST_DONE);
    w_send     = (r_state == ST_SEND);
    w_load     = (r_state == ST_LATCH);
    o_run_log  = 1'b0;
`ifdef LOG_READER_AUTORUN_EN
    o_run_log  = (r_state == ST_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (w_abort || (r_state == ST_IDLE))
        r_addr <= '0;
      else if (w_send && w_word_done)
        r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
    end
  end

  assign o_addr_log_to_mem = r_addr;
  assign o_err             = r_err;

  log_word_serializer #(
    .DATA_W (BRAM_DATA_WIDTH)
  ) u_ser (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_word      (i_data_log_from_mem),
    .i_active    (w_send),
    .o_tdata     (o_tx_data),
    .o_tvalid    (o_tx_valid),
    .i_tready    (i_tx_ready),
    .o_word_done (w_word_done)
  );

endmodule

// File: tb/tb_log_mem_reader.sv
// tb/tb_log_mem_reader.sv - directed bench for log_mem_reader with a small logger model
module tb_log_mem_reader;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int NW = 1 << AW;
`ifdef LOG_READER_AUTORUN_EN
  localparam int EXP_RUN = 1;
`else
  localparam int EXP_RUN = 0;
`endif

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic            i_mem_full;
  logic [2*DW-1:0] i_data_log_from_mem;
  logic            o_read_log;
  logic [AW-1:0]   o_addr_log_to_mem;
  logic            o_run_log;
  logic [7:0]      o_tx_data;
  logic            o_tx_valid;
  logic            i_tx_ready;
  logic            o_busy;
  logic            o_done;
  logic            o_err;

  always #5 clk = ~clk;

  log_mem_reader #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW)
  ) dut (
    .clk                 (clk),
    .i_rst               (i_rst),
    .i_start             (i_start),
    .i_mem_full          (i_mem_full),
    .i_data_log_from_mem (i_data_log_from_mem),
    .o_read_log          (o_read_log),
    .o_addr_log_to_mem   (o_addr_log_to_mem),
    .o_run_log           (o_run_log),
    .o_tx_data           (o_tx_data),
    .o_tx_valid          (o_tx_valid),
    .i_tx_ready          (i_tx_ready),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_err               (o_err)
  );

  // Logger model: word = {addr+0x80, addr}, one cycle read latency.
  logic [2*DW-1:0] mem [NW];
  initial for (int a = 0; a < NW; a++) mem[a] = {16'(a + 'h80), 16'(a)};
  always @(posedge clk) i_data_log_from_mem <= mem[o_addr_log_to_mem];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         byte_q[$];
  int         bcyc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         err_cnt  = 0;
  int         run_cnt  = 0;
  int         run_mis  = 0;
  int         rl_cnt   = 0;
  int         rl_rise  = 0;
  int         stab_err = 0;
  logic       prev_rl    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready) begin
      byte_q.push_back(int'(o_tx_data));
      bcyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (o_err) err_cnt <= err_cnt + 1;
    if (o_run_log) run_cnt <= run_cnt + 1;
    if (o_run_log && !o_done) run_mis <= run_mis + 1;
    if (o_read_log) rl_cnt <= rl_cnt + 1;
    if (o_read_log && !prev_rl) rl_rise <= cyc;
    if (prev_stall && (!o_tx_valid || o_tx_data != prev_data)) stab_err <= stab_err + 1;
    prev_stall <= o_tx_valid && !i_tx_ready;
    prev_data  <= o_tx_data;
    prev_rl    <= o_read_log;
  end

  int n_vec     = 0;
  int n_miscmp  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  function automatic int exp_byte(input int i);
    int a;
    a = i / 4;
    case (i % 4)
      0:       return a;
      2:       return a + 'h80;
      default: return 0;
    endcase
  endfunction

  function automatic int get_b(input int idx);
    return (idx < byte_q.size()) ? byte_q[idx] : -1;
  endfunction

  function automatic int get_c(input int idx);
    return (idx < bcyc_q.size()) ? bcyc_q[idx] : -1;
  endfunction

  // Runs until the block returns to IDLE; bp=1 drives ready at about 30% duty.
  task automatic run_dump(input int budget, input int bp, input int restart_at, output int timed_out);
    timed_out = 1;
    for (int k = 0; k < budget; k++) begin
      i_tx_ready = (bp != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
      i_start    = (k == restart_at);
      tick(1);
      if (!o_busy) begin
        timed_out = 0;
        break;
      end
    end
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
  endtask

  task automatic wait_bytes(input int base, input int n, output int reached);
    reached = 0;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      if (byte_q.size() - base >= n) begin
        reached = 1;
        break;
      end
    end
  endtask

  int base, d0, e0, r0, rl0, s0, to, bad, ok;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_mem_full = 1'b0; i_tx_ready = 1'b1;
    tick(3);
    chk("rst_busy",     int'(o_busy),            0);
    chk("rst_valid",    int'(o_tx_valid),        0);
    chk("rst_read_log", int'(o_read_log),        0);
    chk("rst_addr",     int'(o_addr_log_to_mem), 0);
    chk("rst_data",     int'(o_tx_data),         0);
    chk("rst_done",     int'(o_done),            0);
    chk("rst_err",      int'(o_err),             0);
    chk("rst_run_log",  int'(o_run_log),         0);
    i_rst = 1'b0;
    tick(1);

    // Basic dump with ready tied high
    base = byte_q.size(); d0 = done_cnt; e0 = err_cnt; r0 = run_cnt; rl0 = rl_cnt;
    i_mem_full = 1'b1;
    pulse_start();
    run_dump(500, 0, -1, to);
    chk("basic_timeout", to, 0);
    chk("basic_nbytes", byte_q.size() - base, 32);
    for (int i = 0; i < 32; i++) chk("basic_byte", get_b(base + i), exp_byte(i));
    for (int i = 0; i < 32; i++)
      chk("basic_byte_cyc", get_c(base + i) - get_c(base), (i / 4) * 6 + (i % 4));
    chk("first_valid_latency", get_c(base) - rl_rise, 4);
    chk("done_after_last", done_cyc - get_c(base + 31), 1);
    chk("basic_done_pulses", done_cnt - d0, 1);
    chk("basic_read_log_cycles", rl_cnt - rl0, 50);
    chk("basic_no_err", err_cnt - e0, 0);
    chk("run_log_pulses", run_cnt - r0, EXP_RUN);
    chk("run_log_with_done", run_mis, 0);
    chk("basic_addr_back_0", int'(o_addr_log_to_mem), 0);

    // Backpressure
    base = byte_q.size(); d0 = done_cnt; s0 = stab_err;
    pulse_start();
    run_dump(3000, 1, -1, to);
    chk("bp_timeout", to, 0);
    chk("bp_nbytes", byte_q.size() - base, 32);
    for (int i = 0; i < 32; i++) chk("bp_byte", get_b(base + i), exp_byte(i));
    chk("bp_data_stable", stab_err - s0, 0);
    chk("bp_done_pulses", done_cnt - d0, 1);

    // Wait for full, then ignore a second start mid-dump
    base = byte_q.size(); d0 = done_cnt;
    i_mem_full = 1'b0;
    pulse_start();
    tick(50);
    chk("wait_busy",     int'(o_busy),     1);
    chk("wait_valid",    int'(o_tx_valid), 0);
    chk("wait_read_log", int'(o_read_log), 0);
    i_mem_full = 1'b1;
    run_dump(500, 0, 10, to);
    chk("wait_timeout", to, 0);
    chk("wait_nbytes", byte_q.size() - base, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (get_b(base + i) != exp_byte(i)) bad++;
    chk("wait_bytes_bad", bad, 0);
    chk("wait_done_pulses", done_cnt - d0, 1);
    tick(5);
    chk("restart_ignored", int'(o_busy), 0);

    // Abort during word 3
    base = byte_q.size(); d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    wait_bytes(base, 13, ok);
    chk("abort_reach_word3", ok, 1);
    i_mem_full = 1'b0;
    tick(1);
    chk("abort_err",      int'(o_err),      1);
    chk("abort_valid",    int'(o_tx_valid), 0);
    chk("abort_read_log", int'(o_read_log), 0);
    chk("abort_busy",     int'(o_busy),     0);
    tick(1);
    chk("abort_err_width", int'(o_err), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_err_count", err_cnt - e0, 1);

    // Reset mid-SEND
    base = byte_q.size(); d0 = done_cnt; e0 = err_cnt;
    i_mem_full = 1'b1;
    pulse_start();
    wait_bytes(base, 5, ok);
    chk("mid_rst_reach_send", ok, 1);
    i_rst = 1'b1;
    tick(1);
    chk("mid_rst_busy",     int'(o_busy),            0);
    chk("mid_rst_valid",    int'(o_tx_valid),        0);
    chk("mid_rst_read_log", int'(o_read_log),        0);
    chk("mid_rst_addr",     int'(o_addr_log_to_mem), 0);
    chk("mid_rst_data",     int'(o_tx_data),         0);
    chk("mid_rst_done",     int'(o_done),            0);
    chk("mid_rst_err",      int'(o_err),             0);
    chk("mid_rst_run_log",  int'(o_run_log),         0);
    i_rst = 1'b0;
    tick(3);
    chk("mid_rst_idle", int'(o_busy), 0);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_err", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/log_mem_reader.md
Name: log_mem_reader

Overview:
- Read-side companion of the I/Q capture logger. The logger fills a buffer of 2^BRAM_ADDR_WIDTH words, each word being two 16-bit BRAM lanes.
- On command, this block waits for the logger's full flag, switches the logger to read mode, and sweeps all addresses.
- Each 32-bit word is serialized into bytes on a valid/ready stream that feeds the UART TX / host uplink.

Parameters:
- BRAM_ADDR_WIDTH, 15, logger address width; a dump is 2^BRAM_ADDR_WIDTH words.
- BRAM_DATA_WIDTH, 16, width of one BRAM lane. Word width is 2*BRAM_DATA_WIDTH. Must be a multiple of 4 so the word is whole bytes.

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle dump request
- i_mem_full  in  1  logger full flag
- i_data_log_from_mem  in  2*BRAM_DATA_WIDTH  logger read word, valid one cycle after its address is sampled
- o_read_log  out  1  read-mode request to the logger
- o_addr_log_to_mem  out  BRAM_ADDR_WIDTH  read address to the logger
- o_run_log  out  1  re-arm pulse to the logger (see Optional Feature)
- o_tx_data  out  8  byte out
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  sink ready
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the dump completes
- o_err  out  1  one-cycle pulse when a dump aborts

Behaviour:
- Reset: state IDLE; every output is 0, including o_addr_log_to_mem=0; shift register and counters are cleared. Reset mid-dump aborts immediately with no o_done and no o_err.
- IDLE: i_start moves to WAIT_FULL. i_start is ignored in all other states.
- WAIT_FULL: waits indefinitely. When i_mem_full=1, moves to REQ.
- REQ (1 cycle): o_read_log goes to 1 and stays 1 until the block returns to IDLE. Address is 0.
- SETTLE (1 cycle): lets the logger enter read mode and enable both lane chip-selects before the first fetch.
- FETCH (1 cycle): address held; the logger BRAM samples it at the end of the cycle.
- LATCH (1 cycle): captures i_data_log_from_mem into the shift register; byte index is cleared.
- SEND:
  - o_tx_valid=1 with o_tx_data = current byte. Byte order is LSB first: [7:0], [15:8], then upward. Lane A bytes go out before lane B bytes.
  - A byte retires on o_tx_valid & i_tx_ready, then the shift register advances.
  - o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
  - After the last byte of a word:
    - if address is all-ones, go to DONE;
    - otherwise increment the address and go to FETCH.
- Word cost is 2 cycles plus the byte handshakes; with i_tx_ready tied high, a word takes 2 + BYTES_PER_WORD cycles.
- DONE (1 cycle): o_done=1, o_read_log drops, address returns to 0, state goes to IDLE.
- Abort: if i_mem_full falls in any state from REQ through SEND, the block pulses o_err for 1 cycle, drops o_tx_valid and o_read_log, and goes to IDLE. A partially sent word is discarded.
- Address never wraps within a dump. Exactly 2^BRAM_ADDR_WIDTH * BYTES_PER_WORD bytes are emitted per successful dump (131072 at defaults).

Optional Feature:
- Macro: LOG_READER_AUTORUN_EN.
- Defined: in DONE, o_run_log=1 for exactly 1 cycle, concurrent with o_done, so the logger re-arms and refills without host action.
- Undefined: o_run_log is tied to 0 and re-arming is left to the host.

Decomposition:
- Package log_pkg holds:
  - the state encoding localparams (IDLE..DONE, 3 bits);
  - the BYTES_PER_WORD constant function, 2*BRAM_DATA_WIDTH/8;
  - the byte-index width.
- One sub-module, log_word_serializer:
  - load strobe plus word in;
  - valid/ready byte out;
  - a last-byte flag back to the FSM.
- The FSM and address counter stay in log_mem_reader.

Test Plan:
All scenarios use BRAM_ADDR_WIDTH=3 and a behavioural logger model that is pre-filled with word = {addr+0x80, addr} per lane, both lanes 16-bit.
- Basic dump: i_mem_full=1, pulse i_start, tx_ready=1 -> exactly 32 bytes, word 0 bytes = 00,00,80,00; o_done pulses 1 cycle after the last byte; o_read_log high from REQ to DONE.
- Latency: with tx_ready=1, the first o_tx_valid is asserted 4 cycles after entering REQ, and consecutive words are separated by exactly 2 idle cycles.
- Backpressure: i_tx_ready pseudo-random 30% duty -> same 32-byte sequence; o_tx_data never changes while valid=1 and ready=0.
- Wait/ignore: i_start with i_mem_full=0 -> block stays in WAIT_FULL, busy=1, valid=0. Raise i_mem_full after 50 cycles -> dump completes. A second i_start during the dump has no effect.
- Abort: drop i_mem_full during word 3 -> o_err 1-cycle pulse, valid=0 the next cycle, no o_done, state IDLE.
- Reset mid-SEND: all outputs 0 the cycle after i_rst. With LOG_READER_AUTORUN_EN defined, a full dump yields an o_run_log 1-cycle pulse coincident with o_done; without the macro, o_run_log stays 0.
